// File: rtl/router_pkg.sv
// Shared router types: flit format, flit type encoding and the injection
// arbiter state encoding.
//   FLIT_t       : {valid, ftype, data} packed flit as seen on every flit bus
//   FLIT_TYPE_t  : HEAD / BODY / TAIL marker carried in each flit
//   ARB_STATE_t  : injection arbiter FSM state
package router_pkg;

   localparam int FLIT_DATA_W = 16;

   typedef enum logic [1:0] {
      FLIT_HEAD = 2'd0,
      FLIT_BODY = 2'd1,
      FLIT_TAIL = 2'd2,
      FLIT_RSVD = 2'd3
   } FLIT_TYPE_t;

   typedef struct packed {
      logic                   valid;
      FLIT_TYPE_t             ftype;
      logic [FLIT_DATA_W-1:0] data;
   } FLIT_t;

   localparam int FLIT_SIZE = $bits(FLIT_t);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_STREAM  = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   typedef enum logic [1:0] {
      ARB_IDLE    = ST_IDLE,
      ARB_GRANT   = ST_GRANT,
      ARB_STREAM  = ST_STREAM,
      ARB_RELEASE = ST_RELEASE
   } ARB_STATE_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin helper: finds the first set bit of req at or after ptr,
// wrapping from N-1 back to 0.
//   req   : request vector
//   ptr   : search start index
//   idx   : selected index (0 when nothing is found)
//   found : at least one request bit is set
module rr_select #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = (int'(ptr) + i) % N;
         if (req[cand]) begin
            idx   = IDX_W'(cand);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flit_injection_arbiter.sv
// Packet-level round-robin arbiter sharing one router injection port.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_enable      : allows new grants (a packet in flight always finishes)
//   i_req         : per-source request, held until granted
//   i_flit        : per-source flit buses
//   o_grant       : one-hot, one-cycle send pulse to the chosen source
//   o_flit        : registered flit towards the router
//   o_owner       : current / last owner index
//   o_busy        : high from GRANT through RELEASE
//   o_timeout     : one-cycle pulse when the watchdog forces a release
//   o_err         : sticky protocol error
//   o_pkt_count   : completed packets, wraps
//
// state       | meaning
// ARB_IDLE    | waiting for an enabled request
// ARB_GRANT   | one-cycle send pulse to o_owner, watchdog cleared
// ARB_STREAM  | forwarding owner flits until TAIL or watchdog expiry
// ARB_RELEASE | one-cycle bubble, round-robin pointer advances
module flit_injection_arbiter
   import router_pkg::*;
#(
   parameter int NUM_SRC        = 4,
   parameter int MAX_PKT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_enable,
   input  logic [NUM_SRC-1:0]         i_req,
   input  FLIT_t                      i_flit [NUM_SRC],
   output logic [NUM_SRC-1:0]         o_grant,
   output FLIT_t                      o_flit,
   output logic [$clog2(NUM_SRC)-1:0] o_owner,
   output logic                       o_busy,
   output logic                       o_timeout,
   output logic                       o_err,
   output logic [15:0]                o_pkt_count
);

   localparam int OWN_W  = $clog2(NUM_SRC);
   localparam int WDOG_W = $clog2(MAX_PKT_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MAX_PKT_CYCLES - 1);
   localparam logic [OWN_W-1:0]  OWN_LAST  = OWN_W'(NUM_SRC - 1);

   ARB_STATE_t        state;
   logic [OWN_W-1:0]  rr_ptr;
   logic [OWN_W-1:0]  sel_idx;
   logic              sel_found;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_next;
   logic              head_seen;
   logic              intruder;
   logic              own_tail;
   FLIT_t             own_flit;

   rr_select #(.N(NUM_SRC), .IDX_W(OWN_W)) u_rr_select (
      .req   (i_req),
      .ptr   (rr_ptr),
      .idx   (sel_idx),
      .found (sel_found)
   );

   assign own_flit  = i_flit[o_owner];
   assign own_tail  = own_flit.valid && (own_flit.ftype == FLIT_TAIL);
   assign wdog_next = wdog + 1'b1;
   assign o_busy    = (state != ARB_IDLE);

   always_comb begin
      o_grant = '0;
      if (state == ARB_GRANT) o_grant[o_owner] = 1'b1;
   end

   // Nobody owns the port in IDLE, so any valid flit there is a violation.
   always_comb begin
      intruder = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (i_flit[s].valid && ((state == ARB_IDLE) || (OWN_W'(s) != o_owner)))
            intruder = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ARB_IDLE;
         rr_ptr      <= '0;
         o_owner     <= '0;
         o_flit      <= '0;
         o_timeout   <= 1'b0;
         o_err       <= 1'b0;
         o_pkt_count <= '0;
         wdog        <= '0;
         head_seen   <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         o_flit    <= '0;
         if (intruder) o_err <= 1'b1;
         case (state)
            ARB_IDLE: begin
               if (i_enable && sel_found) begin
                  o_owner <= sel_idx;
                  state   <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               wdog      <= '0;
               head_seen <= 1'b0;
               state     <= ARB_STREAM;
            end
            ARB_STREAM: begin
               wdog <= wdog_next;
               if (own_flit.valid) begin
                  o_flit    <= own_flit;
                  head_seen <= 1'b1;
                  if (!head_seen && (own_flit.ftype != FLIT_HEAD)) o_err <= 1'b1;
               end
               // TAIL takes priority over a watchdog expiry in the same cycle.
               if (own_tail) begin
                  o_pkt_count <= o_pkt_count + 16'd1;
                  state       <= ARB_RELEASE;
               end else if (wdog_next == WDOG_LAST) begin
                  o_timeout <= 1'b1;
                  state     <= ARB_RELEASE;
               end
            end
            ARB_RELEASE: begin
               rr_ptr <= (o_owner == OWN_LAST) ? '0 : o_owner + 1'b1;
               state  <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: doc/flit_injection_arbiter.md
Name: flit_injection_arbiter

Overview:
Packet-level round-robin arbiter that shares one router injection port between NUM_SRC flit sources (traffic generators or NI packetizers). Each source raises a request when a full packet is buffered. The arbiter grants exactly one source with a one-cycle send pulse, forwards that source's flits (registered) until the TAIL flit passes, then releases the port. A watchdog stops a hung packet from locking the port.

Parameters:
NUM_SRC, 4, number of requesting sources (≥2)
MAX_PKT_CYCLES, 64, cycles allowed from grant to TAIL before forced release (≥4)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_enable  in  1  permit new grants; an in-flight packet always completes
i_req  in  NUM_SRC  per-source request, level, held until granted
i_flit  in  NUM_SRC x FLIT_SIZE  per-source flit bus (FLIT_t array)
o_grant  out  NUM_SRC  one-hot send pulse to the chosen source
o_flit  out  FLIT_SIZE  forwarded flit to router input (FLIT_t)
o_owner  out  $clog2(NUM_SRC)  index of the current/last owner
o_busy  out  1  high from GRANT through RELEASE
o_timeout  out  1  one-cycle pulse on watchdog release
o_err  out  1  sticky protocol error
o_pkt_count  out  16  completed packets (TAIL seen), wraps at 0xFFFF→0

Behaviour:
- Reset (async): state IDLE, o_grant=0, o_flit='0, o_owner=0, rr pointer=0, o_busy=0, o_timeout=0, o_err=0, o_pkt_count=0, watchdog=0.
- FSM states: IDLE, GRANT, STREAM, RELEASE.
- IDLE: if i_enable && |i_req, select the first requester at or after the rr pointer, cyclic wrap NUM_SRC-1→0. Register it into o_owner → GRANT. Otherwise stay in IDLE.
- GRANT (exactly 1 cycle): o_grant[o_owner]=1, all other grant bits 0, watchdog cleared → STREAM.
- STREAM:
  - Each cycle o_flit <= i_flit[o_owner] when that flit's valid=1, else '0. Fixed one-cycle latency.
  - First valid flit from the owner must be HEAD. Otherwise set o_err and keep forwarding.
  - Owner flit valid with type TAIL: o_pkt_count += 1, → RELEASE.
  - Watchdog increments every STREAM cycle. When it reaches MAX_PKT_CYCLES-1 with no TAIL: o_timeout=1 for one cycle, → RELEASE, o_pkt_count unchanged.
  - TAIL and timeout in the same cycle: TAIL wins, no timeout pulse.
- RELEASE (1 cycle, bubble): o_flit='0, rr pointer = o_owner+1 mod NUM_SRC → IDLE. Back-to-back packets from different sources therefore have at least one idle flit-slot between the last TAIL and the next grant.
- Non-owner sources: their flits are never forwarded. A valid flit from a non-owner in any state sets o_err (sticky until reset).
- o_flit is '0 in IDLE, GRANT and RELEASE. It is never driven by more than one source.
- i_enable low: no transition out of IDLE. A packet already in STREAM runs to TAIL or timeout.
- A requester dropping i_req before grant is simply not selected. Requests are sampled only in IDLE.
- Fairness: with all sources requesting continuously, grant order is 0,1,…,NUM_SRC-1,0,…
- Reset asserted mid-packet returns everything to reset values immediately. Any partially forwarded packet is abandoned; the router side must also be reset.

Decomposition:
- router_pkg additions: ARB_STATE_t enum (IDLE/GRANT/STREAM/RELEASE). Reuse the existing FLIT_t, FLIT_TYPE_t and FLIT_SIZE.
- Sub-module rr_select: combinational first-set-bit search from a start pointer with wrap. Inputs: req vector and pointer. Outputs: index and found. Reusable by router output arbiters.
- FSM, watchdog, counters and flit register stay in the top module.

Test Plan:
- Single source 2, NUM_SRC=4: i_req=4'b0100 → o_grant=4'b0100 for one cycle. HEAD,BODY,BODY,TAIL appear on o_flit each one cycle after input. o_pkt_count=1, o_owner=2, o_err=0.
- Sources 0 and 1 request together, each sending a 4-flit packet, then re-request → grant order 0,1,0. Exactly one-cycle RELEASE bubble between packets.
- Source 3 granted but never sends TAIL, MAX_PKT_CYCLES=8 → o_timeout pulses exactly once, 8 cycles after GRANT. o_pkt_count unchanged. Next requester (0) granted afterwards.
- Source 1 streaming while source 2 drives a valid BODY flit → source 2's flit never appears on o_flit. o_err=1 and stays 1 until reset.
- i_enable=0 with i_req=4'b1111 → no grant for 20 cycles. Drop i_enable mid-packet → current packet completes, no further grant until i_enable=1.
- Assert reset_n low during STREAM → o_flit, o_grant, o_busy, o_pkt_count, o_err all 0 asynchronously. After release, the first grant goes to source 0.
